id_exe_hazard_ctrl: RTL and testbench

- Sequencing controller for the ID/EXE pipeline register and its fetch-side neighbours.
- Decides each cycle whether the ID/EXE register loads the decoded instruction, loads a bubble, or holds.
- Detects load-use hazards and flushes on taken branches resolved in EXE.
- Expands LDM/STM/PUSH/POP register lists into one ID/EXE transfer per register, driving the per-transfer register index, address offset and write enables.

---
 rtl/id_exe_hazard_ctrl_if.sv | 53 +++++
 rtl/id_exe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_id_exe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_exe_hazard_ctrl_if.sv
// ID/EXE hazard controller bus: decode/EXE status in, pipeline sequencing controls out.
// The slave modport is the controller; the master modport is the pipeline side driving it.
interface id_exe_hazard_ctrl_if #(
    parameter int LIST_W = 9
);
    logic              id_valid;
    logic              id_use_n;
    logic              id_use_m;
    logic              id_use_t;
    logic [3:0]        id_addr_n;
    logic [3:0]        id_addr_m;
    logic [3:0]        id_addr_t;
    logic              exe_is_load;
    logic              exe_w_reg_en;
    logic [3:0]        exe_addr_d;
    logic              exe_branch_taken;
    logic              id_multiple;
    logic              id_mult_load;
    logic              id_mult_hi_pc;
    logic [LIST_W-1:0] id_reg_list;

    logic              stall_pc;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              bubble_id_exe;
    logic              mult_busy;
    logic [3:0]        addr_i;
    logic [31:0]       ri_offset;
    logic              w_mem_en_multiple;
    logic              w_reg_en_multiple;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;

    modport slave (
        input  id_valid, id_use_n, id_use_m, id_use_t,
        input  id_addr_n, id_addr_m, id_addr_t,
        input  exe_is_load, exe_w_reg_en, exe_addr_d, exe_branch_taken,
        input  id_multiple, id_mult_load, id_mult_hi_pc, id_reg_list,
        output stall_pc, stall_if_id, flush_if_id, bubble_id_exe, mult_busy,
        output addr_i, ri_offset, w_mem_en_multiple, w_reg_en_multiple,
        output perf_stall_cnt, perf_flush_cnt
    );

    modport master (
        output id_valid, id_use_n, id_use_m, id_use_t,
        output id_addr_n, id_addr_m, id_addr_t,
        output exe_is_load, exe_w_reg_en, exe_addr_d, exe_branch_taken,
        output id_multiple, id_mult_load, id_mult_hi_pc, id_reg_list,
        input  stall_pc, stall_if_id, flush_if_id, bubble_id_exe, mult_busy,
        input  addr_i, ri_offset, w_mem_en_multiple, w_reg_en_multiple,
        input  perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/id_exe_hazard_ctrl.sv
// ID/EXE sequencing: load-use stalls, taken-branch flushes, LDM/STM/PUSH/POP list expansion.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module id_exe_hazard_ctrl #(
    parameter int LIST_W           = 9,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int BRANCH_BUBBLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    id_exe_hazard_ctrl_if.slave      bus
);
    localparam int NUM_W = $clog2(LIST_W + 1);

    typedef enum logic [1:0] {IDLE, LU_STALL, BR_FLUSH, MULTI} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [LIST_W-1:0] list, list_nxt;
    logic [NUM_W-1:0]  num, num_nxt;
    logic              hi_pc, hi_pc_nxt;
    logic              load, load_nxt;

    logic              hazard;
    logic              issue;
    logic [LIST_W-1:0] cur_list, rem_list;
    logic [NUM_W-1:0]  cur_num;
    logic              cur_hi_pc, cur_load;

    logic              stall_pc, stall_if_id, flush_if_id, bubble_id_exe, mult_busy;
    logic [3:0]        addr_i;
    logic [31:0]       ri_offset;
    logic              w_mem_en, w_reg_en;

    // Register index of the lowest set list bit; the top bit selects LR or PC.
    function automatic logic [3:0] xfer_reg(input logic [LIST_W-1:0] l, input logic hp);
        logic [3:0] r;
        r = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (l[i]) r = (i >= 8) ? (hp ? 4'd15 : 4'd14) : 4'(i);
        end
        return r;
    endfunction

    assign hazard = bus.exe_is_load && bus.exe_w_reg_en && bus.id_valid &&
                    ((bus.id_use_n && bus.id_addr_n == bus.exe_addr_d) ||
                     (bus.id_use_m && bus.id_addr_m == bus.exe_addr_d) ||
                     (bus.id_use_t && bus.id_addr_t == bus.exe_addr_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            list  <= '0;
            num   <= '0;
            hi_pc <= 1'b0;
            load  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            list  <= list_nxt;
            num   <= num_nxt;
            hi_pc <= hi_pc_nxt;
            load  <= load_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        list_nxt      = list;
        num_nxt       = num;
        hi_pc_nxt     = hi_pc;
        load_nxt      = load;
        issue         = 1'b0;
        cur_list      = list;
        cur_num       = num;
        cur_hi_pc     = hi_pc;
        cur_load      = load;
        rem_list      = '0;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        mult_busy     = 1'b0;
        addr_i        = '0;
        ri_offset     = '0;
        w_mem_en      = 1'b0;
        w_reg_en      = 1'b0;

        if (bus.exe_branch_taken) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
            list_nxt      = '0;
            num_nxt       = '0;
            if (BRANCH_BUBBLES > 1) begin
                state_nxt = BR_FLUSH;
                cnt_nxt   = 2'(BRANCH_BUBBLES - 2);
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (hazard) begin
                        stall_pc      = 1'b1;
                        stall_if_id   = 1'b1;
                        bubble_id_exe = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_nxt = LU_STALL;
                            cnt_nxt   = 2'(LOAD_USE_BUBBLES - 2);
                        end
                    end else if (bus.id_multiple && bus.id_valid && bus.id_reg_list != '0) begin
                        issue     = 1'b1;
                        cur_list  = bus.id_reg_list;
                        cur_num   = '0;
                        cur_hi_pc = bus.id_mult_hi_pc;
                        cur_load  = bus.id_mult_load;
                    end
                end
                LU_STALL: begin
                    stall_pc      = 1'b1;
                    stall_if_id   = 1'b1;
                    bubble_id_exe = 1'b1;
                    if (cnt == 2'd0) state_nxt = IDLE;
                    else             cnt_nxt   = cnt - 2'd1;
                end
                BR_FLUSH: begin
                    flush_if_id   = 1'b1;
                    bubble_id_exe = 1'b1;
                    if (cnt == 2'd0) state_nxt = IDLE;
                    else             cnt_nxt   = cnt - 2'd1;
                end
                MULTI: begin
                    issue = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // One transfer per cycle; ID stays stalled until the last list bit is issued.
        if (issue) begin
            addr_i    = xfer_reg(cur_list, cur_hi_pc);
            ri_offset = {{(32 - NUM_W - 2){1'b0}}, cur_num, 2'b00};
            w_reg_en  = cur_load;
            w_mem_en  = ~cur_load;
            rem_list  = cur_list & (cur_list - 1'b1);
            list_nxt  = rem_list;
            hi_pc_nxt = cur_hi_pc;
            load_nxt  = cur_load;
            if (rem_list != '0) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                mult_busy   = 1'b1;
                num_nxt     = cur_num + 1'b1;
                state_nxt   = MULTI;
            end else begin
                num_nxt   = '0;
                state_nxt = IDLE;
            end
        end

        // Outputs read as all-zero for as long as reset is held, even mid-sequence.
        if (rst) begin
            stall_pc      = 1'b0;
            stall_if_id   = 1'b0;
            flush_if_id   = 1'b0;
            bubble_id_exe = 1'b0;
            mult_busy     = 1'b0;
            addr_i        = '0;
            ri_offset     = '0;
            w_mem_en      = 1'b0;
            w_reg_en      = 1'b0;
        end
    end

    assign bus.stall_pc          = stall_pc;
    assign bus.stall_if_id       = stall_if_id;
    assign bus.flush_if_id       = flush_if_id;
    assign bus.bubble_id_exe     = bubble_id_exe;
    assign bus.mult_busy         = mult_busy;
    assign bus.addr_i            = addr_i;
    assign bus.ri_offset         = ri_offset;
    assign bus.w_mem_en_multiple = w_mem_en;
    assign bus.w_reg_en_multiple = w_reg_en;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    // Branch events only; BR_FLUSH extension cycles are not separate events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && stall_cnt != '1)             stall_cnt <= stall_cnt + 32'd1;
            if (bus.exe_branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Directed bench for id_exe_hazard_ctrl: one default instance plus one with 2-cycle bubbles.
module tb_id_exe_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    id_exe_hazard_ctrl_if #(.LIST_W(9)) b  ();
    id_exe_hazard_ctrl_if #(.LIST_W(9)) b2 ();

    id_exe_hazard_ctrl #(.LIST_W(9), .LOAD_USE_BUBBLES(1), .BRANCH_BUBBLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    id_exe_hazard_ctrl #(.LIST_W(9), .LOAD_USE_BUBBLES(2), .BRANCH_BUBBLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        b.id_valid = 0;  b.id_use_n = 0;  b.id_use_m = 0;  b.id_use_t = 0;
        b.id_addr_n = 0; b.id_addr_m = 0; b.id_addr_t = 0;
        b.exe_is_load = 0; b.exe_w_reg_en = 0; b.exe_addr_d = 0; b.exe_branch_taken = 0;
        b.id_multiple = 0; b.id_mult_load = 0; b.id_mult_hi_pc = 0; b.id_reg_list = '0;
        b2.id_valid = 0;  b2.id_use_n = 0;  b2.id_use_m = 0;  b2.id_use_t = 0;
        b2.id_addr_n = 0; b2.id_addr_m = 0; b2.id_addr_t = 0;
        b2.exe_is_load = 0; b2.exe_w_reg_en = 0; b2.exe_addr_d = 0; b2.exe_branch_taken = 0;
        b2.id_multiple = 0; b2.id_mult_load = 0; b2.id_mult_hi_pc = 0; b2.id_reg_list = '0;
    endtask

    task automatic set_mult(input logic ld, input logic hp, input logic [8:0] l);
        b.id_valid = 1; b.id_multiple = 1; b.id_mult_load = ld;
        b.id_mult_hi_pc = hp; b.id_reg_list = l;
    endtask

    initial begin
        int flush_exp;
        n_vec = 0;
        n_err = 0;
        rst = 1;
        clear_in();

        // Reset state
        @(negedge clk);
        chk("rst_stall_pc", {31'b0, b.stall_pc}, 0);
        chk("rst_flush", {31'b0, b.flush_if_id}, 0);
        chk("rst_bubble", {31'b0, b.bubble_id_exe}, 0);
        chk("rst_busy", {31'b0, b.mult_busy}, 0);
        chk("rst_ri", b.ri_offset, 0);
        tick();
        rst = 0;

        // Load-use: exe loads r3, ID reads Rn = r3
        b.exe_is_load = 1; b.exe_w_reg_en = 1; b.exe_addr_d = 3;
        b.id_valid = 1; b.id_use_n = 1; b.id_addr_n = 3;
        @(negedge clk);
        chk("lu_stall_pc", {31'b0, b.stall_pc}, 1);
        chk("lu_stall_ifid", {31'b0, b.stall_if_id}, 1);
        chk("lu_bubble", {31'b0, b.bubble_id_exe}, 1);
        chk("lu_flush", {31'b0, b.flush_if_id}, 0);
        tick();
        b.exe_is_load = 0;
        @(negedge clk);
        chk("lu_release", {31'b0, b.stall_pc}, 0);
        b.exe_is_load = 1; b.id_addr_n = 4;
        #1;
        chk("lu_diff_reg", {31'b0, b.stall_pc}, 0);
        b.id_addr_n = 3; b.id_use_n = 0; b.id_use_t = 1; b.id_addr_t = 3;
        #1;
        chk("lu_rt", {31'b0, b.stall_pc}, 1);
        b.id_use_t = 0;
        #1;
        chk("lu_no_use", {31'b0, b.stall_pc}, 0);
        tick();
        clear_in();

        // Two-bubble load-use on the second instance
        b2.exe_is_load = 1; b2.exe_w_reg_en = 1; b2.exe_addr_d = 3;
        b2.id_valid = 1; b2.id_use_m = 1; b2.id_addr_m = 3;
        @(negedge clk);
        chk("lu2_c0", {31'b0, b2.stall_pc}, 1);
        tick();
        b2.exe_is_load = 0;
        @(negedge clk);
        chk("lu2_c1", {29'b0, b2.stall_pc, b2.stall_if_id, b2.bubble_id_exe}, 3'b111);
        tick();
        @(negedge clk);
        chk("lu2_c2", {29'b0, b2.stall_pc, b2.stall_if_id, b2.bubble_id_exe}, 3'b000);
        tick();
        clear_in();

        // Taken branch in IDLE
        b.exe_branch_taken = 1;
        @(negedge clk);
        chk("br_flush", {31'b0, b.flush_if_id}, 1);
        chk("br_bubble", {31'b0, b.bubble_id_exe}, 1);
        chk("br_stall_pc", {31'b0, b.stall_pc}, 0);
        tick();
        b.exe_branch_taken = 0;
        @(negedge clk);
        chk("br_done", {31'b0, b.flush_if_id}, 0);
`ifdef HAZARD_PERF_CNT_EN
        flush_exp = 1;
`else
        flush_exp = 0;
`endif
        chk("br_perf_flush", b.perf_flush_cnt, 32'(flush_exp));
        tick();

        // Two-cycle branch flush on the second instance
        b2.exe_branch_taken = 1;
        @(negedge clk);
        chk("br2_c0", {31'b0, b2.flush_if_id}, 1);
        tick();
        b2.exe_branch_taken = 0;
        @(negedge clk);
        chk("br2_c1", {30'b0, b2.flush_if_id, b2.bubble_id_exe}, 2'b11);
        tick();
        @(negedge clk);
        chk("br2_c2", {31'b0, b2.flush_if_id}, 0);
        tick();

        // STM {r1,r2,r4}; a load-use on a read register mid-sequence is ignored
        set_mult(0, 0, 9'b000010110);
        @(negedge clk);
        chk("stm0_addr", {28'b0, b.addr_i}, 1);
        chk("stm0_ri", b.ri_offset, 0);
        chk("stm0_wmem", {30'b0, b.w_mem_en_multiple, b.w_reg_en_multiple}, 2'b10);
        chk("stm0_stall", {30'b0, b.stall_pc, b.mult_busy}, 2'b11);
        tick();
        b.exe_is_load = 1; b.exe_w_reg_en = 1; b.exe_addr_d = 3;
        b.id_use_n = 1; b.id_addr_n = 3;
        @(negedge clk);
        chk("stm1_addr", {28'b0, b.addr_i}, 2);
        chk("stm1_ri", b.ri_offset, 4);
        chk("stm1_stall", {31'b0, b.stall_pc}, 1);
        chk("stm1_no_lu_bubble", {31'b0, b.bubble_id_exe}, 0);
        tick();
        b.exe_is_load = 0; b.id_use_n = 0;
        @(negedge clk);
        chk("stm2_addr", {28'b0, b.addr_i}, 4);
        chk("stm2_ri", b.ri_offset, 8);
        chk("stm2_wmem", {31'b0, b.w_mem_en_multiple}, 1);
        chk("stm2_release", {30'b0, b.stall_pc, b.mult_busy}, 2'b00);
        tick();
        clear_in();
        @(negedge clk);
        chk("stm_after", {31'b0, b.w_mem_en_multiple}, 0);
        tick();

        // POP full list with PC
        set_mult(1, 1, 9'h1FF);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("pop%0d_addr", i), {28'b0, b.addr_i}, (i < 8) ? 32'(i) : 32'd15);
            chk($sformatf("pop%0d_ri", i), b.ri_offset, 32'(4 * i));
            chk($sformatf("pop%0d_wreg", i), {31'b0, b.w_reg_en_multiple}, 1);
            chk($sformatf("pop%0d_stall", i), {31'b0, b.stall_pc}, (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        clear_in();

        // Single-bit PUSH {LR}: one transfer, no stall
        set_mult(0, 0, 9'h100);
        @(negedge clk);
        chk("one_addr", {28'b0, b.addr_i}, 14);
        chk("one_stall", {30'b0, b.stall_pc, b.mult_busy}, 2'b00);
        chk("one_wmem", {31'b0, b.w_mem_en_multiple}, 1);
        tick();
        clear_in();

        // Empty list: no enables, no stall, no bubble
        set_mult(1, 0, 9'h000);
        @(negedge clk);
        chk("empty_en", {30'b0, b.w_mem_en_multiple, b.w_reg_en_multiple}, 2'b00);
        chk("empty_ctl", {30'b0, b.stall_pc, b.bubble_id_exe}, 2'b00);
        tick();
        clear_in();

        // Branch during 2nd transfer of LDM {r0-r3}
        set_mult(1, 0, 9'h00F);
        @(negedge clk);
        chk("ldmbr0_addr", {28'b0, b.addr_i}, 0);
        tick();
        b.exe_branch_taken = 1;
        @(negedge clk);
        chk("ldmbr1_flush", {30'b0, b.flush_if_id, b.bubble_id_exe}, 2'b11);
        chk("ldmbr1_wreg", {31'b0, b.w_reg_en_multiple}, 0);
        tick();
        clear_in();
        @(negedge clk);
        chk("ldmbr2_busy", {31'b0, b.mult_busy}, 0);
        chk("ldmbr2_wreg", {31'b0, b.w_reg_en_multiple}, 0);
        chk("ldmbr2_flush", {31'b0, b.flush_if_id}, 0);
        tick();

        // Asynchronous reset in mid-MULTI
        set_mult(1, 0, 9'h00F);
        tick();
        @(negedge clk);
        chk("rstm_pre_ri", b.ri_offset, 4);
        #2;
        rst = 1;
        #1;
        chk("rstm_busy", {31'b0, b.mult_busy}, 0);
        chk("rstm_stall", {31'b0, b.stall_pc}, 0);
        chk("rstm_wreg", {31'b0, b.w_reg_en_multiple}, 0);
        chk("rstm_ri", b.ri_offset, 0);
        tick();
        rst = 0;
        set_mult(1, 0, 9'h00C);
        @(negedge clk);
        chk("rstm_new_ri", b.ri_offset, 0);
        chk("rstm_new_addr", {28'b0, b.addr_i}, 2);
        tick();
        clear_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
